mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder to the control unit's `read`/`write`/`sread`/`swrite` strobes. It holds the main word-addressed RAM, which is addressed by MAR, and the hardware LIFO used by the stack load and stack store instructions. The block answers every strobe in the same cycle, as the control unit's fixed-length sequences require, and it detects protocol faults. A LOAD phase lets the bench or boot logic preload the program image before the CPU runs.

## Interface
- `ADDR_W`, 9, RAM address width; RAM holds 2^ADDR_W words.
- `DATA_W`, 32, word width.
- `STK_DEPTH`, 16, LIFO capacity in words.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `load_done` in 1: ends the preload phase.
- `init_we` in 1: preload write enable.
- `init_addr` in ADDR_W: preload write address.
- `init_data` in DATA_W: preload write data.
- `mar` in 32: memory address from MAR.
- `wdata` in DATA_W: MDR contents, the write source for `write` and `swrite`.
- `read`, `write` in 1: main memory strobes.
- `sread`, `swrite` in 1: stack pop and push strobes.
- `rdata` out DATA_W: main memory read data, combinational.
- `stk_rdata` out DATA_W: stack pop data, combinational.
- `sp` out clog2(STK_DEPTH+1): stack pointer, equal to the number of words held.
- `stk_empty`, `stk_full` out 1: stack status.
- `fault` out 1: set when the block is in the FAULT state.
- `fault_code` out 3: code of the first fault.
- `state_out` out 2: current state.

## Operation
- The block has three states:
  - LOAD = 0.
  - RUN = 1.
  - FAULT = 2.
- Reset takes the block to LOAD and sets `sp`=0, `fault`=0, `fault_code`=0, `stk_empty`=1 and `stk_full`=0. Reset does not clear the RAM or the stack array.
- In LOAD:
  - `init_we` writes `init_data` to `mem[init_addr]`.
  - CPU strobes are ignored and never fault.
  - `rdata` and `stk_rdata` read 0.
  - When `load_done` is high, the block moves to RUN on the next edge. An `init_we` in that same cycle is still performed.
- In RUN, `init_we` is ignored.
- Address is in range when `mar[31:ADDR_W]`==0.
- `read`: `rdata` = `mem[mar[ADDR_W-1:0]]`.
- `write`: `mem[mar]` <= `wdata` at the edge.
- `swrite` (push): `stack[sp]` <= `wdata`, `sp` <= `sp`+1.
- `sread` (pop): `stk_rdata` = `stack[sp-1]`, `sp` <= `sp`-1.
- When no strobe is active, `rdata` and `stk_rdata` are 0.
- Fault detection in RUN uses priority order; only the highest-priority matching code is recorded:
  - 1 CONFLICT: two or more strobes high in the same cycle.
  - 2 OVERFLOW: `swrite` with `sp`==STK_DEPTH.
  - 3 UNDERFLOW: `sread` with `sp`==0.
  - 4 ADDR: `read` or `write` with the address out of range.
- A faulting cycle performs no state update: no RAM write, no stack write, no `sp` change. Read outputs return 0 in that cycle.
- On the next edge the block enters FAULT and latches `fault_code`.
- FAULT is terminal until reset:
  - All strobes are ignored.
  - `sp` and the RAM are frozen.
  - Read outputs are 0.
  - `fault_code` holds.
- `stk_empty` = (`sp`==0) and `stk_full` = (`sp`==STK_DEPTH), both registered alongside `sp`.

## Timing
- Read latency is 0 cycles: `rdata` and `stk_rdata` are valid in the strobe cycle, so MDR captures them at that cycle's closing edge.
- Write, push and `sp` updates are visible from the next cycle. For example, a write at edge N followed by a read of the same address in cycle N+1 returns the new data.
- Pop and push must not occur in the same cycle; that combination is a CONFLICT.
- `fault` rises one cycle after the faulting strobe.
- Reset asserted mid-RUN or mid-FAULT takes effect at the next edge and overrides all strobes.

## Structure
- Shared package holds:
  - State encodings LOAD, RUN and FAULT.
  - Fault codes NONE=0, CONFLICT=1, OVERFLOW=2, UNDERFLOW=3, ADDR=4.
  - Default widths.
- Sub-module `stack_lifo`:
  - Contains the array, `sp`, the `stk_empty`/`stk_full` flags and the combinational top-of-stack read.
  - Push and pop enables are pre-qualified by the parent.
- The parent holds the RAM array, the FSM, fault detection and output gating.

## Test plan
- Preload `mem[5]`=0xDEADBEEF, pulse `load_done`, then `read` with `mar`=5 → `rdata`=0xDEADBEEF in the strobe cycle; `state_out`=1.
- `write` `mar`=7, `wdata`=0x1234; next cycle `read` `mar`=7 → 0x1234.
- Push 0xA, 0xB, 0xC → `sp`=3. Pop three times → `stk_rdata` = 0xC, 0xB, 0xA, then `sp`=0 and `stk_empty`=1.
- Push 16 words (`stk_full`=1), then a 17th `swrite` → `fault`=1 next cycle, `fault_code`=2, `sp` stays 16. Later strobes are ignored.
- `sread` with `sp`=0 → `fault_code`=3. Separately, `read` and `swrite` together → `fault_code`=1 with no RAM or stack change.
- `read` with `mar`=0x200 → `rdata`=0 and `fault_code`=4. Then `reset` → `state_out`=0, `sp`=0, `fault`=0, and the RAM contents preloaded earlier are still readable after `load_done`.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encodings,
// fault codes and default widths.
package mem_responder_pkg;

  localparam int ADDR_W_DEF    = 9;
  localparam int DATA_W_DEF    = 32;
  localparam int STK_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    FLT_NONE      = 3'd0,
    FLT_CONFLICT  = 3'd1,
    FLT_OVERFLOW  = 3'd2,
    FLT_UNDERFLOW = 3'd3,
    FLT_ADDR      = 3'd4
  } fault_t;

endpackage

// File: rtl/stack_lifo.sv
// Hardware LIFO used by the stack load/store instructions.
// Ports:
//   clk, reset        - clock, synchronous active-high reset (clears sp only)
//   push, pop         - pre-qualified enables (never both, never push when full,
//                       never pop when empty)
//   push_data         - word written at stack[sp] on push
//   top_data          - combinational stack[sp-1]
//   sp                - number of words held
//   empty, full       - registered status flags, updated alongside sp
module stack_lifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int SP_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top_data,
  output logic [SP_W-1:0]   sp,
  output logic              empty,
  output logic              full
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] stack_mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [SP_W-1:0]   sp_nxt;

  // With a power-of-two depth, sp==DEPTH wraps wr_idx to 0 and rd_idx to
  // DEPTH-1, so the top of a full stack is still addressed correctly.
  assign wr_idx   = sp[IDX_W-1:0];
  assign rd_idx   = wr_idx - IDX_W'(1);
  assign top_data = stack_mem[rd_idx];

  always_comb begin
    sp_nxt = sp;
    if (push)
      sp_nxt = sp + SP_W'(1);
    else if (pop)
      sp_nxt = sp - SP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      sp    <= sp_nxt;
      empty <= (sp_nxt == '0);
      full  <= (sp_nxt == SP_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      stack_mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: main RAM addressed by MAR, hardware LIFO, preload
// phase and protocol-fault detection. Reads are answered in the strobe cycle.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   load_done                  - leave LOAD at the next edge
//   init_we/init_addr/init_data- preload write port (LOAD only)
//   mar, wdata                 - CPU address and write data
//   read, write, sread, swrite - CPU strobes
//   rdata, stk_rdata           - combinational read data (0 when not serving)
//   sp, stk_empty, stk_full    - stack status
//   fault, fault_code          - terminal fault flag and first fault code
//   state_out                  - current FSM state
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF,
  parameter int SP_W      = $clog2(STK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_done,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [31:0]       mar,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read,
  input  logic              write,
  input  logic              sread,
  input  logic              swrite,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] stk_rdata,
  output logic [SP_W-1:0]   sp,
  output logic              stk_empty,
  output logic              stk_full,
  output logic              fault,
  output logic [2:0]        fault_code,
  output logic [1:0]        state_out
);

  state_t            state, state_nxt;
  fault_t            flt;
  logic              in_range;
  logic              multi_strobe;
  logic              serve;
  logic              push, pop;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] top_data;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign in_range     = (mar[31:ADDR_W] == '0);
  assign multi_strobe = ($countones({read, write, sread, swrite}) > 1);

  // Faults are only raised in RUN; LOAD and FAULT ignore the strobes entirely.
  always_comb begin
    flt = FLT_NONE;
    if (state == ST_RUN) begin
      if (multi_strobe)
        flt = FLT_CONFLICT;
      else if (swrite && stk_full)
        flt = FLT_OVERFLOW;
      else if (sread && stk_empty)
        flt = FLT_UNDERFLOW;
      else if ((read || write) && !in_range)
        flt = FLT_ADDR;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (load_done) state_nxt = ST_RUN;
      ST_RUN:   if (flt != FLT_NONE) state_nxt = ST_FAULT;
      default:  state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LOAD;
      fault_code <= FLT_NONE;
    end else begin
      state <= state_nxt;
      if (flt != FLT_NONE)
        fault_code <= flt;
    end
  end

  // A strobe is served only in a clean RUN cycle; reset blocks every update.
  assign serve = (state == ST_RUN) && (flt == FLT_NONE) && !reset;
  assign push  = serve && swrite;
  assign pop   = serve && sread;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_addr;
    mem_wdata = init_data;
    if (state == ST_LOAD) begin
      mem_we = init_we && !reset;
    end else if (serve && write) begin
      mem_we    = 1'b1;
      mem_waddr = mar[ADDR_W-1:0];
      mem_wdata = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  assign rdata     = (serve && read)  ? mem[mar[ADDR_W-1:0]] : '0;
  assign stk_rdata = (serve && sread) ? top_data : '0;

  stack_lifo #(
    .DEPTH  (STK_DEPTH),
    .DATA_W (DATA_W),
    .SP_W   (SP_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (wdata),
    .top_data  (top_data),
    .sp        (sp),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  assign fault     = (state == ST_FAULT);
  assign state_out = state;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_done;
  logic        init_we;
  logic [8:0]  init_addr;
  logic [31:0] init_data;
  logic [31:0] mar;
  logic [31:0] wdata;
  logic        read, write, sread, swrite;
  logic [31:0] rdata, stk_rdata;
  logic [4:0]  sp;
  logic        stk_empty, stk_full, fault;
  logic [2:0]  fault_code;
  logic [1:0]  state_out;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .load_done  (load_done),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_data  (init_data),
    .mar        (mar),
    .wdata      (wdata),
    .read       (read),
    .write      (write),
    .sread      (sread),
    .swrite     (swrite),
    .rdata      (rdata),
    .stk_rdata  (stk_rdata),
    .sp         (sp),
    .stk_empty  (stk_empty),
    .stk_full   (stk_full),
    .fault      (fault),
    .fault_code (fault_code),
    .state_out  (state_out)
  );

  typedef struct {
    logic        rd, wr, srd, swr;
    logic [31:0] mar, wdata;
    logic [31:0] exp_rdata, exp_stk;
    int          exp_sp;
    logic [1:0]  exp_state;
    logic [2:0]  exp_code;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string nm, input int esp, input logic [1:0] est,
                          input logic [2:0] ec);
    chk({nm, ".sp"},    32'(sp),         32'(esp));
    chk({nm, ".empty"}, 32'(stk_empty),  32'(esp == 0));
    chk({nm, ".full"},  32'(stk_full),   32'(esp == 16));
    chk({nm, ".state"}, 32'(state_out),  32'(est));
    chk({nm, ".fault"}, 32'(fault),      32'(est == 2'd2));
    chk({nm, ".code"},  32'(fault_code), 32'(ec));
  endtask

  task automatic idle_inputs();
    read = 0; write = 0; sread = 0; swrite = 0;
    init_we = 0; load_done = 0;
  endtask

  // One CPU cycle: drive after negedge, check combinational outputs, then
  // check registered state after the closing edge.
  task automatic step(input string nm, input logic r, input logic w, input logic sr,
                      input logic sw, input logic [31:0] m, input logic [31:0] wd,
                      input logic [31:0] er, input logic [31:0] es, input int esp,
                      input logic [1:0] est, input logic [2:0] ec);
    @(negedge clk);
    read = r; write = w; sread = sr; swrite = sw; mar = m; wdata = wd;
    #2;
    chk({nm, ".rdata"}, rdata, er);
    chk({nm, ".stk_rdata"}, stk_rdata, es);
    @(posedge clk);
    #1;
    chk_regs(nm, esp, est, ec);
    idle_inputs();
  endtask

  // Reset with strobes asserted: the strobes must have no effect.
  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1; write = 1; swrite = 1; mar = 32'd7; wdata = 32'h0BAD;
    @(posedge clk);
    #1;
    chk_regs(nm, 0, 2'd0, 3'd0);
    @(negedge clk);
    reset = 0;
    idle_inputs();
  endtask

  // One LOAD cycle with every CPU strobe high; they must be ignored.
  task automatic load_cycle(input string nm, input logic we, input logic [8:0] a,
                            input logic [31:0] d, input logic done);
    @(negedge clk);
    init_we = we; init_addr = a; init_data = d; load_done = done;
    read = 1; write = 1; sread = 1; swrite = 1; mar = 32'd5; wdata = 32'h0BAD;
    #2;
    chk({nm, ".rdata"}, rdata, 32'h0);
    chk({nm, ".stk_rdata"}, stk_rdata, 32'h0);
    @(posedge clk);
    #1;
    chk_regs(nm, 0, done ? 2'd1 : 2'd0, 3'd0);
    idle_inputs();
  endtask

  initial begin
    reset = 1; mar = 0; wdata = 0; init_addr = 0; init_data = 0;
    idle_inputs();

    //        rd wr sr sw  mar        wdata     exp_rdata      exp_stk  sp st code
    tbl[0]  = '{1, 0, 0, 0, 32'd5,     32'h0,    32'hDEADBEEF,  32'h0,   0, 1, 0};
    tbl[1]  = '{0, 1, 0, 0, 32'd7,     32'h1234, 32'h0,         32'h0,   0, 1, 0};
    tbl[2]  = '{1, 0, 0, 0, 32'd7,     32'h0,    32'h1234,      32'h0,   0, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 32'd9,     32'h0,    32'h99,        32'h0,   0, 1, 0};
    tbl[4]  = '{0, 0, 0, 1, 32'd0,     32'hA,    32'h0,         32'h0,   1, 1, 0};
    tbl[5]  = '{0, 0, 0, 1, 32'd0,     32'hB,    32'h0,         32'h0,   2, 1, 0};
    tbl[6]  = '{0, 0, 0, 1, 32'd0,     32'hC,    32'h0,         32'h0,   3, 1, 0};
    tbl[7]  = '{0, 0, 1, 0, 32'd0,     32'h0,    32'h0,         32'hC,   2, 1, 0};
    tbl[8]  = '{0, 0, 1, 0, 32'd0,     32'h0,    32'h0,         32'hB,   1, 1, 0};
    tbl[9]  = '{0, 0, 1, 0, 32'd0,     32'h0,    32'h0,         32'hA,   0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 32'd5,     32'h0,    32'h0,         32'h0,   0, 1, 0};
    tbl[11] = '{0, 1, 0, 0, 32'h1FF,   32'h55,   32'h0,         32'h0,   0, 1, 0};
    tbl[12] = '{1, 0, 0, 0, 32'h1FF,   32'h0,    32'h55,        32'h0,   0, 1, 0};

    @(posedge clk);
    #1;
    chk_regs("reset", 0, 2'd0, 3'd0);
    @(negedge clk);
    reset = 0;

    load_cycle("load0", 1, 9'd5, 32'hDEADBEEF, 0);
    load_cycle("load1", 1, 9'd7, 32'h0, 0);
    load_cycle("load2", 1, 9'd9, 32'h99, 1);

    for (int i = 0; i < 13; i++)
      step($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].srd, tbl[i].swr,
           tbl[i].mar, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_stk,
           tbl[i].exp_sp, tbl[i].exp_state, tbl[i].exp_code);

    // Fill the stack, then overflow it.
    for (int i = 0; i < 16; i++)
      step($sformatf("push%0d", i), 0, 0, 0, 1, 0, 32'h100 + 32'(i), 0, 0, i + 1, 2'd1, 3'd0);
    step("ovf",       0, 0, 0, 1, 0,     32'h999, 0, 0, 16, 2'd2, 3'd2);
    step("flt_pop",   0, 0, 1, 0, 0,     0,       0, 0, 16, 2'd2, 3'd2);
    step("flt_write", 0, 1, 0, 0, 32'd7, 32'hBAD, 0, 0, 16, 2'd2, 3'd2);
    step("flt_read",  1, 0, 0, 0, 32'd7, 0,       0, 0, 16, 2'd2, 3'd2);

    do_reset("rst1");
    load_cycle("ld_a", 0, 9'd0, 0, 1);
    step("keep7_a", 1, 0, 0, 0, 32'd7, 0, 32'h1234, 0, 0, 2'd1, 3'd0);
    step("udf",     0, 0, 1, 0, 0,     0, 0,        0, 0, 2'd2, 3'd3);
    step("udf_hold",0, 0, 0, 0, 0,     0, 0,        0, 0, 2'd2, 3'd3);

    do_reset("rst2");
    load_cycle("ld_b", 0, 9'd0, 0, 1);
    step("push1",   0, 0, 0, 1, 0,     32'h77,  0, 0, 1, 2'd1, 3'd0);
    step("cnf_ws",  0, 1, 0, 1, 32'd7, 32'hBAD, 0, 0, 1, 2'd2, 3'd1);
    do_reset("rst3");
    load_cycle("ld_c", 0, 9'd0, 0, 1);
    step("keep7_b", 1, 0, 0, 0, 32'd7, 0, 32'h1234, 0, 0, 2'd1, 3'd0);
    step("cnf_rs",  1, 0, 0, 1, 32'd5, 32'h1, 0, 0, 0, 2'd2, 3'd1);
    do_reset("rst4");
    load_cycle("ld_d", 0, 9'd0, 0, 1);
    step("cnf_pp",  0, 0, 1, 1, 0,     32'h1, 0, 0, 0, 2'd2, 3'd1);

    do_reset("rst5");
    load_cycle("ld_e", 0, 9'd0, 0, 1);
    step("addr_w",  0, 1, 0, 0, 32'h80000007, 32'hBAD, 0, 0, 0, 2'd2, 3'd4);
    do_reset("rst6");
    load_cycle("ld_f", 0, 9'd0, 0, 1);
    step("keep7_c", 1, 0, 0, 0, 32'd7, 0, 32'h1234, 0, 0, 2'd1, 3'd0);
    step("addr_r",  1, 0, 0, 0, 32'h200, 0, 0, 0, 0, 2'd2, 3'd4);
    do_reset("rst7");
    load_cycle("ld_g", 0, 9'd0, 0, 1);
    step("keep5",   1, 0, 0, 0, 32'd5, 0, 32'hDEADBEEF, 0, 0, 2'd1, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
